up_word_bridge: RTL and testbench
=================================

# up_word_bridge

Parametrised microcontroller-to-FPGA register bridge. It moves DATA_WIDTH-bit register words over a narrow BUS_WIDTH-bit parallel bus using a four-phase req/ack handshake, and generates register-bank read/write strobes plus a soft-reset pulse. It is the generalised successor of the 8-bit single-register uP interface, with multi-byte words, read-back, byte counting and a handshake timeout. It sits between the top-level microcontroller pins and the register bank.

## Interface
Parameters:
- BUS_WIDTH, 8, width of the microcontroller data bus.
- DATA_WIDTH, 32, register word width; must be an integer multiple of BUS_WIDTH.
- ADDR_WIDTH, 8, register address width; must be ≤ BUS_WIDTH.
- TIMEOUT_CYCLES, 1000, clk cycles allowed in any wait state before abort; ≥ 4.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- uP_req  in  1  handshake from the microcontroller; asynchronous to clk.
- uP_rw  in  1  direction, sampled with the command byte: 0 = write, 1 = read.
- uP_data_in  in  BUS_WIDTH  byte from the microcontroller.
- uP_data_out  out  BUS_WIDTH  byte to the microcontroller.
- uP_data_oe  out  1  drive enable for the top-level tristate.
- uP_ack  out  1  handshake to the microcontroller.
- reg_address  out  ADDR_WIDTH  latched register address.
- reg_wr_data  out  DATA_WIDTH  assembled write word.
- reg_wr_strobe  out  1  one-cycle write pulse.
- reg_rd_strobe  out  1  one-cycle read request.
- reg_rd_data  in  DATA_WIDTH  read word; valid the cycle after reg_rd_strobe.
- soft_reset  out  1  one-cycle soft-reset pulse.
- timeout_err  out  1  one-cycle pulse on abort.
- busy  out  1  high in every state except S_IDLE.

## Operation
- uP_req passes through a 2-flop synchroniser to give req_s. uP_data_in and uP_rw are sampled only when req_s is seen high.
- BYTES = DATA_WIDTH/BUS_WIDTH. Bytes travel least-significant first in both directions.
- Every transaction starts with a command byte. Its low ADDR_WIDTH bits are the register address.
- Address all-ones (SOFT_RESET_ADDR) is reserved. It carries no data phase and produces a soft_reset pulse.
- State machine:
  - S_IDLE: on req_s=1, latch reg_address and rw, set ack=1, go to S_CMD_ACK.
  - S_CMD_ACK: on req_s=0, set ack=0. Then:
    - if address is SOFT_RESET_ADDR: pulse soft_reset, go to S_IDLE;
    - else if rw=0: set count=BYTES, go to S_WR_REQ;
    - else: pulse reg_rd_strobe, go to S_RD_LOAD.
  - S_WR_REQ: on req_s=1, shift the byte into the top of the shift register (shift right), set ack=1, go to S_WR_ACK.
  - S_WR_ACK: on req_s=0, set ack=0 and decrement count. When count reaches 0 go to S_WR_COMMIT, else go to S_WR_REQ.
  - S_WR_COMMIT: reg_wr_data = shift register, reg_wr_strobe=1 for one cycle, go to S_IDLE.
  - S_RD_LOAD: load the shift register from reg_rd_data, set count=BYTES, go to S_RD_REQ.
  - S_RD_REQ: drive uP_data_out = shift[BUS_WIDTH-1:0] with uP_data_oe=1. On req_s=1 set ack=1, go to S_RD_ACK.
  - S_RD_ACK: on req_s=0, set ack=0, shift right by BUS_WIDTH, decrement count. When count reaches 0 go to S_IDLE, else go to S_RD_REQ.
- uP_data_oe is 1 only in S_RD_REQ and S_RD_ACK.
- Timeout counter:
  - cleared on every state change and held at 0 in S_IDLE;
  - on reaching TIMEOUT_CYCLES-1: ack=0, oe=0, pulse timeout_err, go to S_IDLE;
  - a partial write never strobes, and reg_wr_data keeps its previous value.
- uP_rw and the address are ignored after the command byte.

## Timing
- Reset values: uP_ack=0, uP_data_oe=0, uP_data_out=0, reg_address=0, reg_wr_data=0, all strobes/pulses=0, busy=0, state=S_IDLE, count=0, shift register=0.
- Reset asserted mid-transaction aborts immediately to these values. No strobe is issued.
- uP_ack rises 3 clk cycles after uP_req rises (2 synchroniser + 1 register); it falls 3 cycles after uP_req falls.
- reg_wr_strobe fires 1 cycle after the final ack falls.
- reg_rd_data is captured 1 cycle after reg_rd_strobe. The first read byte is on the bus 2 cycles after the command ack falls.
- All outputs are registered.

## Structure
- Shared package (global_constants): the state enum type, SOFT_RESET_ADDR, the default BUS_WIDTH/DATA_WIDTH.
- Sub-module `handshake_sync`: a parametrised N-flop synchroniser, reusable for other asynchronous inputs.
- The FSM, counters and shift register live in up_word_bridge.

## Test plan
Defaults: DATA_WIDTH=32, BUS_WIDTH=8.
- Write: cmd 0x05 (rw=0), bytes 0x78, 0x56, 0x34, 0x12 → one reg_wr_strobe, reg_address=0x05, reg_wr_data=0x12345678.
- Read: cmd 0x03 (rw=1), reg_rd_data=0xCAFEF00D → one reg_rd_strobe; bus returns 0x0D, 0xF0, 0xFE, 0xCA with oe high; oe low afterwards.
- Soft reset: cmd 0xFF → single-cycle soft_reset, no rd/wr strobe, busy low within 1 cycle of ack falling.
- Timeout: cmd 0x05 plus 2 bytes, then the uC stalls → timeout_err after TIMEOUT_CYCLES, no wr_strobe. A following full write succeeds.
- Reset mid-read after byte 2 → ack=0, oe=0, busy=0 immediately. The next read at 0x03 returns all 4 bytes correctly.
- Handshake latency: measure uP_req↑ to uP_ack↑ as exactly 3 cycles, and uP_req↓ to uP_ack↓ as exactly 3 cycles.

Source files
------------

// File: rtl/up_word_bridge_pkg.sv
// Shared constants for the microcontroller register bridge: default widths,
// the reserved soft-reset address and the bridge state encoding.
// Pure declarations, no logic.
package up_word_bridge_pkg;

  localparam int unsigned DEF_BUS_WIDTH  = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 8;

  // All-ones address is reserved: no data phase, issues soft_reset instead.
  localparam logic [DEF_ADDR_WIDTH-1:0] SOFT_RESET_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ACK,
    S_WR_REQ,
    S_WR_ACK,
    S_WR_COMMIT,
    S_RD_LOAD,
    S_RD_REQ,
    S_RD_ACK
  } state_t;

endpackage

// File: rtl/up_word_bridge_handshake_sync.sv
// Purpose: N-flop synchroniser for a single asynchronous level input.
// Latency: STAGES clk cycles from input change to q.
// Backpressure: none, free-running.
// Ports: clk, reset (async active-high), d (async input), q (synchronised).
module handshake_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/up_word_bridge.sv
// Purpose: four-phase req/ack bridge moving DATA_WIDTH register words over a BUS_WIDTH uC bus.
// Latency: ack follows req edges by 3 clk; write strobe 1 clk after last ack falls; first read byte 2 clk after command ack falls.
// Backpressure: the uC paces every byte via req; any wait state stalled TIMEOUT_CYCLES aborts to idle.
// Ports: uP_* microcontroller pins, reg_* register-bank side, soft_reset / timeout_err pulses, busy status.
module up_word_bridge
  import up_word_bridge_pkg::*;
#(
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uP_req,
  input  logic                  uP_rw,
  input  logic [BUS_WIDTH-1:0]  uP_data_in,
  output logic [BUS_WIDTH-1:0]  uP_data_out,
  output logic                  uP_data_oe,
  output logic                  uP_ack,
  output logic [ADDR_WIDTH-1:0] reg_address,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_wr_strobe,
  output logic                  reg_rd_strobe,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  soft_reset,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / BUS_WIDTH;
  localparam int CW    = $clog2(BYTES + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]         BYTES_C  = CW'(BYTES);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] SRST_ADDR = '1;

  logic req_s;

  handshake_sync #(.STAGES(2)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uP_req),
    .q     (req_s)
  );

  state_t                state_q, state_nxt;
  logic [CW-1:0]         count_q, count_nxt;
  logic [TW-1:0]         tmo_q, tmo_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic                  rw_q, rw_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic [BUS_WIDTH-1:0]  dout_nxt;
  logic                  ack_nxt, oe_nxt, wr_stb_nxt, rd_stb_nxt;
  logic                  srst_nxt, terr_nxt, busy_nxt;

  always_comb begin
    state_nxt   = state_q;
    count_nxt   = count_q;
    shift_nxt   = shift_q;
    rw_nxt      = rw_q;
    addr_nxt    = reg_address;
    wr_data_nxt = reg_wr_data;
    ack_nxt     = uP_ack;
    wr_stb_nxt  = 1'b0;
    rd_stb_nxt  = 1'b0;
    srst_nxt    = 1'b0;
    terr_nxt    = 1'b0;

    case (state_q)
      S_IDLE: if (req_s) begin
        addr_nxt  = uP_data_in[ADDR_WIDTH-1:0];
        rw_nxt    = uP_rw;
        ack_nxt   = 1'b1;
        state_nxt = S_CMD_ACK;
      end
      S_CMD_ACK: if (!req_s) begin
        ack_nxt = 1'b0;
        if (reg_address == SRST_ADDR) begin
          srst_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (!rw_q) begin
          count_nxt = BYTES_C;
          state_nxt = S_WR_REQ;
        end else begin
          rd_stb_nxt = 1'b1;
          state_nxt  = S_RD_LOAD;
        end
      end
      S_WR_REQ: if (req_s) begin
        // Bytes arrive LSB first, so each new byte enters at the top.
        shift_nxt = (shift_q >> BUS_WIDTH) |
                    (DATA_WIDTH'(uP_data_in) << (DATA_WIDTH - BUS_WIDTH));
        ack_nxt   = 1'b1;
        state_nxt = S_WR_ACK;
      end
      S_WR_ACK: if (!req_s) begin
        ack_nxt   = 1'b0;
        count_nxt = count_q - CW'(1);
        state_nxt = (count_q == CW'(1)) ? S_WR_COMMIT : S_WR_REQ;
      end
      S_WR_COMMIT: begin
        wr_data_nxt = shift_q;
        wr_stb_nxt  = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_RD_LOAD: begin
        // The bank answers the cycle after the strobe: the first cycle here
        // (tmo_q == 0) is the strobe cycle, the second holds valid data.
        if (tmo_q != '0) begin
          shift_nxt = reg_rd_data;
          count_nxt = BYTES_C;
          state_nxt = S_RD_REQ;
        end
      end
      S_RD_REQ: if (req_s) begin
        ack_nxt   = 1'b1;
        state_nxt = S_RD_ACK;
      end
      S_RD_ACK: if (!req_s) begin
        ack_nxt   = 1'b0;
        shift_nxt = shift_q >> BUS_WIDTH;
        count_nxt = count_q - CW'(1);
        state_nxt = (count_q == CW'(1)) ? S_IDLE : S_RD_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Stall abort overrides whatever the state wanted to do this cycle.
    if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      state_nxt   = S_IDLE;
      ack_nxt     = 1'b0;
      wr_stb_nxt  = 1'b0;
      rd_stb_nxt  = 1'b0;
      srst_nxt    = 1'b0;
      wr_data_nxt = reg_wr_data;
      terr_nxt    = 1'b1;
    end

    tmo_nxt  = (state_q == S_IDLE || state_nxt != state_q) ? '0 : tmo_q + TW'(1);
    oe_nxt   = (state_nxt == S_RD_REQ) || (state_nxt == S_RD_ACK);
    dout_nxt = oe_nxt ? shift_nxt[BUS_WIDTH-1:0] : '0;
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      tmo_q         <= '0;
      shift_q       <= '0;
      rw_q          <= 1'b0;
      reg_address   <= '0;
      reg_wr_data   <= '0;
      uP_ack        <= 1'b0;
      uP_data_oe    <= 1'b0;
      uP_data_out   <= '0;
      reg_wr_strobe <= 1'b0;
      reg_rd_strobe <= 1'b0;
      soft_reset    <= 1'b0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      count_q       <= count_nxt;
      tmo_q         <= tmo_nxt;
      shift_q       <= shift_nxt;
      rw_q          <= rw_nxt;
      reg_address   <= addr_nxt;
      reg_wr_data   <= wr_data_nxt;
      uP_ack        <= ack_nxt;
      uP_data_oe    <= oe_nxt;
      uP_data_out   <= dout_nxt;
      reg_wr_strobe <= wr_stb_nxt;
      reg_rd_strobe <= rd_stb_nxt;
      soft_reset    <= srst_nxt;
      timeout_err   <= terr_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_up_word_bridge.sv
// Purpose: self-checking bench for up_word_bridge with a behavioural uC and register bank.
// Latency: n/a (simulation only).
// Backpressure: n/a; the bench plays the uC and paces every handshake itself.
module tb_up_word_bridge;

  localparam int BW  = 8;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int TMO = 1000;
  localparam int NB  = DW / BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uP_req = 1'b0;
  logic          uP_rw = 1'b0;
  logic [BW-1:0] uP_data_in = '0;
  logic [BW-1:0] uP_data_out;
  logic          uP_data_oe;
  logic          uP_ack;
  logic [AW-1:0] reg_address;
  logic [DW-1:0] reg_wr_data;
  logic          reg_wr_strobe;
  logic          reg_rd_strobe;
  logic [DW-1:0] reg_rd_data = '0;
  logic          soft_reset;
  logic          timeout_err;
  logic          busy;

  always #5 clk = ~clk;

  up_word_bridge #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uP_req        (uP_req),
    .uP_rw         (uP_rw),
    .uP_data_in    (uP_data_in),
    .uP_data_out   (uP_data_out),
    .uP_data_oe    (uP_data_oe),
    .uP_ack        (uP_ack),
    .reg_address   (reg_address),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_rd_strobe (reg_rd_strobe),
    .reg_rd_data   (reg_rd_data),
    .soft_reset    (soft_reset),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor: every strobe/pulse is a registered one-cycle signal, so
  // sampling on the falling edge sees each high cycle exactly once.
  int            wr_cnt = 0, rd_cnt = 0, srst_hi = 0, srst_rise = 0;
  logic          srst_prev = 1'b0;
  logic [AW-1:0] wr_addr_seen = '0, rd_addr_seen = '0;
  logic [DW-1:0] wr_data_seen = '0;
  logic          rd_pend = 1'b0;
  logic [DW-1:0] rd_value = '0;

  always @(negedge clk) begin
    rd_pend = reg_rd_strobe;
    if (reg_wr_strobe) begin
      wr_cnt++;
      wr_addr_seen = reg_address;
      wr_data_seen = reg_wr_data;
    end
    if (reg_rd_strobe) begin
      rd_cnt++;
      rd_addr_seen = reg_address;
    end
    if (soft_reset) srst_hi++;
    if (soft_reset && !srst_prev) srst_rise++;
    srst_prev = soft_reset;
  end

  // Register bank: read word is valid only for the one cycle after the strobe.
  always begin
    @(posedge clk);
    #1;
    reg_rd_data = rd_pend ? rd_value : DW'($urandom);
  end

  logic [BW-1:0] last_byte;
  logic          last_oe;

  // One four-phase byte transfer; checks ack latency in both directions.
  task automatic hs(input logic [BW-1:0] d, input logic rw, input string tag);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    uP_data_in = d;
    uP_rw      = rw;
    uP_req     = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (uP_ack !== 1'b1 && n < 50);
    chk({tag, "_ack_rise"}, n, 3);
    last_byte = uP_data_out;
    last_oe   = uP_data_oe;
    uP_req     = 1'b0;
    uP_data_in = BW'($urandom);
    uP_rw      = 1'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (uP_ack !== 1'b0 && n < 50);
    chk({tag, "_ack_fall"}, n, 3);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int w0;
    w0 = wr_cnt;
    hs(BW'(addr), 1'b0, "wcmd");
    for (int i = 0; i < NB; i++)
      hs(BW'(data >> (BW * i)), 1'($urandom), "wbyte");
    @(negedge clk);
    chk("wr_stb_time", reg_wr_strobe, 1);
    @(negedge clk);
    chk("wr_count", wr_cnt, w0 + 1);
    chk("wr_addr", wr_addr_seen, addr);
    chk("wr_data", wr_data_seen, data);
    chk("wr_busy", busy, 0);
  endtask

  // Starts a read and returns once the first byte is on the bus.
  task automatic start_read(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    int n;
    rd_value = val;
    hs(BW'(addr), 1'b1, "rcmd");
    n = 0;
    while (uP_data_oe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rd_first_lat", n, 2);
  endtask

  task automatic read_byte(input logic [DW-1:0] val, input int i);
    hs(BW'($urandom), 1'($urandom), "rbyte");
    chk("rd_byte", last_byte, (val >> (BW * i)) & 32'hFF);
    chk("rd_oe", last_oe, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    int r0;
    r0 = rd_cnt;
    start_read(addr, val);
    for (int i = 0; i < NB; i++) read_byte(val, i);
    @(negedge clk);
    chk("rd_oe_off", uP_data_oe, 0);
    chk("rd_count", rd_cnt, r0 + 1);
    chk("rd_addr", rd_addr_seen, addr);
    chk("rd_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, s0, sr0, n;
    logic [DW-1:0] prev_wd;

    repeat (3) @(negedge clk);
    chk("rst_ack", uP_ack, 0);
    chk("rst_oe", uP_data_oe, 0);
    chk("rst_dout", uP_data_out, 0);
    chk("rst_addr", reg_address, 0);
    chk("rst_wdata", reg_wr_data, 0);
    chk("rst_strobes", {reg_wr_strobe, reg_rd_strobe, soft_reset, timeout_err}, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Directed write and read.
    do_write(8'h05, 32'h12345678);
    do_read(8'h03, 32'hCAFEF00D);

    // Soft reset command.
    w0 = wr_cnt; r0 = rd_cnt; s0 = srst_hi; sr0 = srst_rise;
    hs(8'hFF, 1'($urandom), "scmd");
    chk("srst_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("srst_rise", srst_rise, sr0 + 1);
    chk("srst_width", srst_hi, s0 + 1);
    chk("srst_no_wr", wr_cnt, w0);
    chk("srst_no_rd", rd_cnt, r0);

    // Stalled write: command plus two bytes, then nothing.
    w0 = wr_cnt;
    prev_wd = reg_wr_data;
    hs(8'h05, 1'b0, "tcmd");
    hs(8'hAA, 1'b0, "tbyte");
    hs(8'hBB, 1'b0, "tbyte");
    n = 0;
    while (timeout_err !== 1'b1 && n < TMO + 50) begin @(negedge clk); n++; end
    chk("tmo_cycles", n, TMO);
    chk("tmo_ack", uP_ack, 0);
    chk("tmo_busy", busy, 0);
    @(negedge clk);
    chk("tmo_pulse_width", timeout_err, 0);
    chk("tmo_no_wr", wr_cnt, w0);
    chk("tmo_wdata_kept", reg_wr_data, prev_wd);
    do_write(8'h05, 32'hA5A55A5A);

    // Reset while byte 3 of a read is being acknowledged.
    w0 = wr_cnt; r0 = rd_cnt;
    start_read(8'h03, 32'h0BADBEEF);
    read_byte(32'h0BADBEEF, 0);
    read_byte(32'h0BADBEEF, 1);
    uP_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (uP_ack !== 1'b1 && n < 50);
    chk("mid_ack_high", uP_ack, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", uP_ack, 0);
    chk("mid_rst_oe", uP_data_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dout", uP_data_out, 0);
    uP_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rd_count", rd_cnt, r0 + 1);
    chk("mid_no_wr", wr_cnt, w0);
    do_read(8'h03, 32'h13579BDF);

    // Random traffic.
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, 254)), DW'($urandom));
      else
        do_read(AW'($urandom_range(0, 254)), DW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
